// File: rtl/and_chain_pipe_pkg.sv
// ---------------------------------------------------------------------------
// and_chain_pkg
// Shared definitions for the and_chain_pipe fold pipeline.
//   op_t    : per-transaction fold operator encoding (AND/OR/XOR/PASS)
//   STAT_W  : width of the optional retired-transaction counter
//   fold()  : single-bit fold; callers apply it lane by lane so the
//             function stays independent of the pipeline's WIDTH parameter
// ---------------------------------------------------------------------------
package and_chain_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_PASS = 2'd3
  } op_t;

  localparam int STAT_W = 16;

  // Bitwise fold of one accumulator bit against one operand bit.
  function automatic logic fold(input logic acc, input logic b, input op_t op);
    logic res;
    case (op)
      OP_AND:  res = acc & b;
      OP_OR:   res = acc | b;
      OP_XOR:  res = acc ^ b;
      OP_PASS: res = acc;
      default: res = acc;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/and_chain_pipe_stage.sv
// ---------------------------------------------------------------------------
// and_chain_stage
// One registered fold stage of and_chain_pipe.
// Ports:
//   CLK, RESET       clock (rising edge), synchronous active-high reset
//   i_up_valid       upstream stage (or input port) holds a transaction
//   i_ready          this stage may load this cycle (computed by the top,
//                    which owns the whole ready ripple)
//   i_up_acc/b/op    upstream accumulator, fold operand and operator
//   o_valid          this stage holds a transaction
//   o_acc            fold(i_up_acc, i_up_b, i_up_op) captured on load
//   o_b, o_op        operand/operator forwarded unchanged
//   o_tap            upstream accumulator captured on load (one fold behind)
// ---------------------------------------------------------------------------
module and_chain_stage
  import and_chain_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             i_up_valid,
  input  logic             i_ready,
  input  logic [WIDTH-1:0] i_up_acc,
  input  logic [WIDTH-1:0] i_up_b,
  input  logic [1:0]       i_up_op,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_b,
  output logic [1:0]       o_op,
  output logic [WIDTH-1:0] o_tap
);

  logic             r_valid;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_tap;
  logic [WIDTH-1:0] w_fold;

  // Lane-by-lane fold of the upstream accumulator.
  always_comb begin
    w_fold = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_fold[i] = fold(i_up_acc[i], i_up_b[i], op_t'(i_up_op));
    end
  end

  // Stage registers: valid follows upstream whenever the stage advances;
  // data only moves when a real transaction is loaded, so a holding or
  // bubble stage keeps its contents.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_valid <= 1'b0;
      r_acc   <= '0;
      r_b     <= '0;
      r_op    <= 2'd0;
      r_tap   <= '0;
    end else if (i_ready) begin
      r_valid <= i_up_valid;
      if (i_up_valid) begin
        r_acc <= w_fold;
        r_b   <= i_up_b;
        r_op  <= i_up_op;
        r_tap <= i_up_acc;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_acc   = r_acc;
  assign o_b     = r_b;
  assign o_op    = r_op;
  assign o_tap   = r_tap;

endmodule

// File: rtl/and_chain_pipe.sv
// ---------------------------------------------------------------------------
// and_chain_pipe
// Pipelined fold chain: operand in_a is folded DEPTH times against in_b with
// the operator in_op, one registered stage per fold, valid/ready on both ends.
// Ports:
//   CLK, RESET        clock (rising edge), synchronous active-high reset
//   in_valid/in_ready input handshake; in_a/in_b/in_op sampled on accept
//   out_valid/out_ready output handshake
//   out_o             result after DEPTH folds
//   out_tap           result after DEPTH-1 folds of the same transaction
// Optional build (macro AND_CHAIN_PIPE_STATS_EN):
//   stat_count        saturating count of retired transactions
//   stat_stall        registered flag: previous cycle had out_valid & !out_ready
// Parameters: WIDTH (lane width), DEPTH (fold stages / latency, 2..16).
// ---------------------------------------------------------------------------
module and_chain_pipe
  import and_chain_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic [1:0]        in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_o,
  output logic [WIDTH-1:0]  out_tap
`ifdef AND_CHAIN_PIPE_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_count,
  output logic              stat_stall
`endif
);

  logic [DEPTH-1:0] w_valid;
  logic [DEPTH-1:0] w_ready;
  logic [WIDTH-1:0] w_acc [DEPTH];
  logic [WIDTH-1:0] w_b   [DEPTH];
  logic [1:0]       w_op  [DEPTH];
  logic [WIDTH-1:0] w_tap [DEPTH];

  // Ready ripples from the output back to the input within one cycle, so a
  // full pipe with out_ready high advances as a whole and still accepts.
  always_comb begin
    logic w_rdy_chain;
    w_rdy_chain = out_ready;
    w_ready     = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      w_rdy_chain = !w_valid[k] | w_rdy_chain;
      w_ready[k]  = w_rdy_chain;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             w_up_valid;
    logic [WIDTH-1:0] w_up_acc;
    logic [WIDTH-1:0] w_up_b;
    logic [1:0]       w_up_op;

    if (k == 0) begin : g_head
      assign w_up_valid = in_valid;
      assign w_up_acc   = in_a;
      assign w_up_b     = in_b;
      assign w_up_op    = in_op;
    end else begin : g_body
      assign w_up_valid = w_valid[k-1];
      assign w_up_acc   = w_acc[k-1];
      assign w_up_b     = w_b[k-1];
      assign w_up_op    = w_op[k-1];
    end

    and_chain_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .CLK       (CLK),
      .RESET     (RESET),
      .i_up_valid(w_up_valid),
      .i_ready   (w_ready[k]),
      .i_up_acc  (w_up_acc),
      .i_up_b    (w_up_b),
      .i_up_op   (w_up_op),
      .o_valid   (w_valid[k]),
      .o_acc     (w_acc[k]),
      .o_b       (w_b[k]),
      .o_op      (w_op[k]),
      .o_tap     (w_tap[k])
    );
  end

  assign in_ready  = w_ready[0];
  assign out_valid = w_valid[DEPTH-1];
  assign out_o     = w_acc[DEPTH-1];
  assign out_tap   = w_tap[DEPTH-1];

`ifdef AND_CHAIN_PIPE_STATS_EN
  logic [STAT_W-1:0] r_stat_count;
  logic              r_stat_stall;

  // Retire counter (saturating) and one-cycle-delayed stall flag.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_stat_count <= '0;
      r_stat_stall <= 1'b0;
    end else begin
      if (out_valid && out_ready && (r_stat_count != {STAT_W{1'b1}})) begin
        r_stat_count <= r_stat_count + STAT_W'(1);
      end
      r_stat_stall <= out_valid & !out_ready;
    end
  end

  assign stat_count = r_stat_count;
  assign stat_stall = r_stat_stall;
`endif

endmodule
